// File: rtl/map_irq_timer_if.sv
// Register and save-state bus between a mapper core and map_irq_timer.
// The mapper drives the master side; the timer is the slave.
interface map_irq_timer_if;
    logic       reg_we;
    logic [3:0] reg_addr;
    logic [7:0] reg_di;
    logic [7:0] reg_do;
    logic       sst_act;
    logic       sst_we;
    logic [3:0] sst_addr;
    logic [7:0] sst_di;
    logic [7:0] sst_do;

    modport master (
        output reg_we, reg_addr, reg_di, sst_act, sst_we, sst_addr, sst_di,
        input  reg_do, sst_do
    );

    modport slave (
        input  reg_we, reg_addr, reg_di, sst_act, sst_we, sst_addr, sst_di,
        output reg_do, sst_do
    );
endinterface

// File: rtl/map_irq_timer.sv
// CPU-cycle IRQ timer with auto-reload, power-of-two prescaler and save-state access.
// Save-state support is compiled in only when MAP_IRQ_TIMER_SST_EN is defined.
module map_irq_timer #(
    parameter int CTR_W = 16,
    parameter int PRE_W = 4
) (
    input  logic            m2,
    input  logic            map_rst,
    map_irq_timer_if.slave  bus,
    output logic            irq
);
    localparam int         NB  = CTR_W / 8;
    localparam logic [1:0] TOP = 2'(NB - 1);

    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [CTR_W-1:0] reload_q, reload_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             en_q, en_d;
    logic             pend_q, pend_d;

    logic [PRE_W-1:0] pre_mask;
    logic             tick;
    logic             sst_on;
    logic             suppress;
    logic [CTR_W-1:0] ctr_step;

    // Unimplemented upper bytes read as zero because the state is zero-extended.
    function automatic logic [7:0] rd_map(input logic [3:0] a, input logic [31:0] c,
                                          input logic [31:0] r, input logic [7:0] cr,
                                          input logic e, input logic p);
        logic [7:0] rd;
        case (a)
            4'd0, 4'd1, 4'd2, 4'd3: rd = c[{a[1:0], 3'b000} +: 8];
            4'd4, 4'd5, 4'd6, 4'd7: rd = r[{a[1:0], 3'b000} +: 8];
            4'd8:                   rd = cr;
            4'd9:                   rd = {6'b0, e, p};
            default:                rd = 8'hFF;
        endcase
        return rd;
    endfunction

    // Divide select is clipped to the prescaler width; mask has s low bits set.
    always_comb begin
        int s_w;
        s_w = (int'(ctrl_q[7:4]) > PRE_W) ? PRE_W : int'(ctrl_q[7:4]);
        pre_mask = '0;
        for (int k = 0; k < PRE_W; k++) begin
            pre_mask[k] = (k < s_w);
        end
    end

    assign tick     = ((pre_q & pre_mask) == pre_mask);
    assign ctr_step = ctrl_q[0] ? (ctr_q - 1'b1) : (ctr_q + 1'b1);

`ifdef MAP_IRQ_TIMER_SST_EN
    assign sst_on     = bus.sst_act;
    assign bus.sst_do = rd_map(bus.sst_addr, 32'(ctr_q), 32'(reload_q), ctrl_q, en_q, pend_q);
`else
    assign sst_on     = 1'b0;
    assign bus.sst_do = 8'hFF;
`endif

    assign bus.reg_do = rd_map(bus.reg_addr, 32'(ctr_q), 32'(reload_q), ctrl_q, en_q, pend_q);
    assign irq        = pend_q;

    always_comb begin
        ctr_d    = ctr_q;
        reload_d = reload_q;
        ctrl_d   = ctrl_q;
        pre_d    = pre_q;
        en_d     = en_q;
        pend_d   = pend_q;
        suppress = 1'b0;

        if (sst_on) begin
            // Frozen session: raw loads only, prescaler held in reset.
            pre_d = '0;
            if (bus.sst_we) begin
                case (bus.sst_addr)
                    4'd0, 4'd1, 4'd2, 4'd3:
                        for (int k = 0; k < NB; k++)
                            if (bus.sst_addr[1:0] == 2'(k)) ctr_d[8*k +: 8] = bus.sst_di;
                    4'd4, 4'd5, 4'd6, 4'd7:
                        for (int k = 0; k < NB; k++)
                            if (bus.sst_addr[1:0] == 2'(k)) reload_d[8*k +: 8] = bus.sst_di;
                    4'd8:    ctrl_d = bus.sst_di;
                    4'd9:    {en_d, pend_d} = bus.sst_di[1:0];
                    default: ;
                endcase
            end
        end else begin
            if (en_q) pre_d = pre_q + 1'b1;

            if (bus.reg_we) begin
                case (bus.reg_addr)
                    4'd0, 4'd1, 4'd2, 4'd3: begin
                        suppress = 1'b1;
                        for (int k = 0; k < NB; k++)
                            if (bus.reg_addr[1:0] == 2'(k)) ctr_d[8*k +: 8] = bus.reg_di;
                        if (bus.reg_addr[1:0] == 2'd0) pend_d = 1'b0;
                        if (bus.reg_addr[1:0] == TOP) begin
                            en_d  = ctrl_q[2];
                            pre_d = '0;
                        end
                    end
                    4'd4, 4'd5, 4'd6, 4'd7: begin
                        suppress = 1'b1;
                        for (int k = 0; k < NB; k++)
                            if (bus.reg_addr[1:0] == 2'(k)) reload_d[8*k +: 8] = bus.reg_di;
                    end
                    4'd8: begin
                        suppress = 1'b1;
                        ctrl_d   = {bus.reg_di[7:4], 1'b0, bus.reg_di[2:0]};
                        if (bus.reg_di[3]) en_d = 1'b1;
                    end
                    4'd9:    pend_d = 1'b0;
                    default: ;
                endcase
            end

            // Terminal set is evaluated after the ack so it wins on a collision.
            if (en_q && tick && !suppress) begin
                if (ctr_q == '0) begin
                    pend_d = 1'b1;
                    if (ctrl_q[1]) begin
                        ctr_d = reload_q;
                    end else begin
                        en_d  = 1'b0;
                        ctr_d = ctr_step;
                    end
                end else begin
                    ctr_d = ctr_step;
                end
            end
        end
    end

    always_ff @(negedge m2 or posedge map_rst) begin
        if (map_rst) begin
            ctr_q    <= '0;
            reload_q <= '0;
            ctrl_q   <= '0;
            pre_q    <= '0;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            ctr_q    <= ctr_d;
            reload_q <= reload_d;
            ctrl_q   <= ctrl_d;
            pre_q    <= pre_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
        end
    end
endmodule

// File: tb/tb_map_irq_timer.sv
// Directed bench for map_irq_timer: stimulus queues expected read values, a monitor compares them.
`timescale 1ns/1ps
module tb_map_irq_timer;
    logic m2 = 1'b1;
    logic map_rst = 1'b1;
    logic irq;
    logic chk_stb = 1'b0;

    map_irq_timer_if bus();

    map_irq_timer #(.CTR_W(16), .PRE_W(4)) dut (
        .m2      (m2),
        .map_rst (map_rst),
        .bus     (bus.slave),
        .irq     (irq)
    );

    always #50 m2 = ~m2;

    typedef struct {
        int         sel;   // 0 reg_do, 1 sst_do, 2 irq
        logic [7:0] exp;
        string      name;
    } item_t;

    item_t sb[$];
    int checks = 0;
    int errors = 0;

    always @(posedge chk_stb) begin : monitor
        item_t      it;
        logic [7:0] act;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: strobe with empty queue");
        end else begin
            it  = sb.pop_front();
            act = (it.sel == 0) ? bus.reg_do : (it.sel == 1) ? bus.sst_do : {7'b0, irq};
            if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got %02h expected %02h", it.name, act, it.exp);
            end else begin
                $display("check %s: got %02h expected %02h ok", it.name, act, it.exp);
            end
        end
    end

    task automatic expect_val(input int sel, input logic [3:0] a, input logic [7:0] exp,
                              input string name);
        item_t it;
        it.sel = sel; it.exp = exp; it.name = name;
        sb.push_back(it);
        if (sel == 1) bus.sst_addr = a; else bus.reg_addr = a;
        #1 chk_stb = 1'b1;
        #1 chk_stb = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(posedge m2); #1;
        bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_di = d;
        @(negedge m2); #1;
        bus.reg_we = 1'b0;
    endtask

    task automatic sst_wr(input logic [3:0] a, input logic [7:0] d);
        @(posedge m2); #1;
        bus.sst_we = 1'b1; bus.sst_addr = a; bus.sst_di = d;
        @(negedge m2); #1;
        bus.sst_we = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge m2);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        bus.reg_we = 1'b0; bus.reg_addr = 4'd0; bus.reg_di = 8'h00;
        bus.sst_act = 1'b0; bus.sst_we = 1'b0; bus.sst_addr = 4'd0; bus.sst_di = 8'h00;
        #120 map_rst = 1'b0;

        // Reset state and address map edges
        expect_val(2, 4'd0, 8'h00, "reset_irq");
        expect_val(0, 4'd9, 8'h00, "reset_status");
        expect_val(0, 4'd8, 8'h00, "reset_ctrl");
        expect_val(0, 4'd0, 8'h00, "reset_ctr0");
        expect_val(0, 4'd10, 8'hFF, "reserved_read");
        expect_val(0, 4'd2, 8'h00, "absent_byte_read");

        // Down count from 3, no reload
        wr(4'd8, 8'h05); wr(4'd0, 8'h03); wr(4'd1, 8'h00);
        idle(3); expect_val(2, 4'd0, 8'h00, "down_irq_before");
        idle(1); expect_val(2, 4'd0, 8'h01, "down_irq_4th");
        expect_val(0, 4'd9, 8'h01, "down_status");
        expect_val(0, 4'd0, 8'hFF, "down_ctr0_wrap");
        expect_val(0, 4'd1, 8'hFF, "down_ctr1_wrap");

        // Up count with reload 0xFFFE
        wr(4'd9, 8'h00); wr(4'd8, 8'h06);
        wr(4'd4, 8'hFE); wr(4'd5, 8'hFF); wr(4'd0, 8'hFE); wr(4'd1, 8'hFF);
        idle(2); expect_val(2, 4'd0, 8'h00, "up_irq_before");
        idle(1); expect_val(2, 4'd0, 8'h01, "up_irq_3rd");
        expect_val(0, 4'd0, 8'hFE, "up_reload_ctr0");
        expect_val(0, 4'd1, 8'hFF, "up_reload_ctr1");
        expect_val(0, 4'd9, 8'h03, "up_status_en");
        wr(4'd9, 8'h00); expect_val(2, 4'd0, 8'h00, "up_ack");
        idle(1); expect_val(2, 4'd0, 8'h00, "up_irq2_before");
        idle(1); expect_val(2, 4'd0, 8'h01, "up_irq2");
        wr(4'd8, 8'h00); wr(4'd1, 8'h00); wr(4'd9, 8'h00);
        expect_val(0, 4'd9, 8'h00, "up_stopped");

        // Prescaler divide-by-4
        wr(4'd8, 8'h25); wr(4'd0, 8'h01); wr(4'd1, 8'h00);
        idle(7); expect_val(2, 4'd0, 8'h00, "pre4_irq_before");
        idle(1); expect_val(2, 4'd0, 8'h01, "pre4_irq_8th");
        expect_val(0, 4'd9, 8'h01, "pre4_status");

        // Divide select 7 clipped to 16
        wr(4'd8, 8'h75); wr(4'd0, 8'h00); wr(4'd1, 8'h00);
        expect_val(2, 4'd0, 8'h00, "pre16_pend_cleared");
        idle(15); expect_val(2, 4'd0, 8'h00, "pre16_irq_before");
        idle(1); expect_val(2, 4'd0, 8'h01, "pre16_irq_16th");

        // Ack colliding with terminal set
        wr(4'd8, 8'h05); wr(4'd0, 8'h01); wr(4'd1, 8'h00);
        idle(1); wr(4'd9, 8'h00);
        expect_val(2, 4'd0, 8'h01, "ack_collision_irq");
        expect_val(0, 4'd9, 8'h01, "ack_collision_status");

        // ctrl write on a tick edge suppresses counting; go starts the timer
        wr(4'd9, 8'h00); wr(4'd0, 8'h10); wr(4'd8, 8'h01); wr(4'd1, 8'h00);
        wr(4'd8, 8'h09);
        expect_val(0, 4'd8, 8'h01, "go_not_stored");
        idle(2); expect_val(0, 4'd0, 8'h0E, "go_counting");
        wr(4'd8, 8'h01); expect_val(0, 4'd0, 8'h0E, "ctrl_write_suppress");
        idle(1); expect_val(0, 4'd0, 8'h0D, "count_resumes");
        expect_val(0, 4'd9, 8'h02, "go_status_en");
        wr(4'd8, 8'h00); wr(4'd1, 8'h00);

        // Asynchronous reset between edges
        wr(4'd8, 8'h05); wr(4'd0, 8'h00); wr(4'd1, 8'h00);
        idle(1); expect_val(2, 4'd0, 8'h01, "pre_reset_irq");
        @(posedge m2); #5;
        map_rst = 1'b1; #1;
        expect_val(2, 4'd0, 8'h00, "async_reset_irq");
        map_rst = 1'b0;
        expect_val(0, 4'd9, 8'h00, "async_reset_status");
        expect_val(0, 4'd8, 8'h00, "async_reset_ctrl");

        // Save-state load and freeze
        bus.sst_act = 1'b1;
        sst_wr(4'd0, 8'h34); sst_wr(4'd1, 8'h12); sst_wr(4'd8, 8'h01); sst_wr(4'd9, 8'h03);
        idle(5);
`ifdef MAP_IRQ_TIMER_SST_EN
        expect_val(0, 4'd0, 8'h34, "sst_frozen_ctr0");
        expect_val(0, 4'd1, 8'h12, "sst_frozen_ctr1");
        expect_val(1, 4'd0, 8'h34, "sst_do_ctr0");
        expect_val(2, 4'd0, 8'h01, "sst_irq_loaded");
`else
        expect_val(0, 4'd0, 8'h00, "sst_off_ctr0");
        expect_val(0, 4'd1, 8'h00, "sst_off_ctr1");
        expect_val(1, 4'd0, 8'hFF, "sst_off_do");
        expect_val(2, 4'd0, 8'h00, "sst_off_irq");
`endif
        bus.sst_act = 1'b0;
        idle(2);
`ifdef MAP_IRQ_TIMER_SST_EN
        expect_val(0, 4'd0, 8'h32, "sst_resume_ctr0");
        expect_val(0, 4'd9, 8'h03, "sst_resume_status");
`else
        expect_val(0, 4'd0, 8'h00, "sst_off_resume_ctr0");
        expect_val(0, 4'd9, 8'h00, "sst_off_resume_status");
`endif

        #5;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
